nco_tdm_sched: RTL and testbench



---
 rtl/nco_pkg.sv | 13 +
 rtl/nco_tag_pipe.sv | 22 ++
 rtl/nco_tdm_sched.sv | 79 +++++++
 tb/tb_nco_tdm_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: shared parameters, config-select codes and channel-index width helper for the TDM NCO scheduler
package nco_pkg;
  localparam int NCH = 4;
  localparam int FSZ = 24;
  localparam int PSZ = 12;
  localparam int OSZ = 14;
  localparam int LAT = 3;
  localparam logic CFG_FREQ = 1'b0;
  localparam logic CFG_OFF = 1'b1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nco_tag_pipe.sv
// nco_tag_pipe: DEPTH-stage valid/channel shift register that tags sine results with their channel
module nco_tag_pipe #(
  parameter int CW = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_i,
  input  logic [CW-1:0] ch_i,
  output logic          vld_o,
  output logic [CW-1:0] ch_o
);
  logic [DEPTH-1:0] vld_q;
  logic [CW-1:0]    ch_q [DEPTH];
  always_ff @(posedge clk) begin
    vld_q <= reset ? '0 : {vld_q[DEPTH-2:0], vld_i};
    ch_q[0] <= ch_i;
    for (int i = 1; i < DEPTH; i++) ch_q[i] <= ch_q[i-1];
  end
  assign vld_o = vld_q[DEPTH-1];
  assign ch_o  = ch_q[DEPTH-1];
endmodule

// File: rtl/nco_tdm_sched.sv
// nco_tdm_sched: round-robin phase-accumulator bank feeding a shared sine unit, with channel-tagged result capture
module nco_tdm_sched
  import nco_pkg::*;
#(
  parameter int NCH = nco_pkg::NCH,
  parameter int FSZ = nco_pkg::FSZ,
  parameter int PSZ = nco_pkg::PSZ,
  parameter int OSZ = nco_pkg::OSZ,
  parameter int LAT = nco_pkg::LAT,
  localparam int CW = ch_w(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [CW-1:0]         cfg_ch,
  input  logic [FSZ-1:0]        cfg_data,
  output logic [PSZ-1:0]        sine_phs,
  input  logic signed [OSZ-1:0] sine_d,
  output logic signed [OSZ-1:0] dout,
  output logic [CW-1:0]         dout_ch,
  output logic                  dout_vld,
  output logic                  frame
);
  logic [CW-1:0]  slot_q, slot_d;
  logic [FSZ-1:0] acc_q [NCH];
  logic [FSZ-1:0] freq_q [NCH];
  logic [PSZ-1:0] off_q [NCH];
  logic [PSZ-1:0] phs_q, phs_d;
  logic           issue, t_vld;
  logic [CW-1:0]  t_ch;
  assign issue = en & ~sync_clr;
  always_comb begin
    phs_d  = issue ? acc_q[slot_q][FSZ-1 -: PSZ] + off_q[slot_q] : phs_q;
    slot_d = sync_clr ? '0 : !issue ? slot_q : (slot_q == CW'(NCH-1)) ? '0 : slot_q + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        freq_q[i] <= '0;
        off_q[i]  <= '0;
      end
      slot_q   <= '0;
      phs_q    <= '0;
      dout     <= '0;
      dout_ch  <= '0;
      dout_vld <= 1'b0;
      frame    <= 1'b0;
    end else begin
      slot_q <= slot_d;
      phs_q  <= phs_d;
      if (sync_clr) begin
        for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
      end else if (issue) begin
        acc_q[slot_q] <= acc_q[slot_q] + freq_q[slot_q];
      end
      if (cfg_we && cfg_sel == CFG_FREQ) freq_q[cfg_ch] <= cfg_data;
      if (cfg_we && cfg_sel == CFG_OFF) off_q[cfg_ch] <= cfg_data[PSZ-1:0];
      dout_vld <= t_vld;
      frame    <= t_vld && t_ch == CW'(NCH-1);
      if (t_vld) begin
        dout    <= sine_d;
        dout_ch <= t_ch;
      end
    end
  end
  assign sine_phs = phs_q;
  nco_tag_pipe #(.CW(CW), .DEPTH(LAT + 1)) u_tag (
    .clk   (clk),
    .reset (reset),
    .vld_i (issue),
    .ch_i  (slot_q),
    .vld_o (t_vld),
    .ch_o  (t_ch)
  );
endmodule

// File: tb/tb_nco_tdm_sched.sv
// tb_nco_tdm_sched: randomized scoreboard bench with a behavioural NCO model and a modelled 3-clock sine unit
module tb_nco_tdm_sched;
  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [23:0] cfg_data = '0;
  logic [11:0] sine_phs;
  logic signed [13:0] sine_d, dout;
  logic [1:0] dout_ch;
  logic dout_vld, frame;
  logic [11:0] p1, p2;
  typedef struct {int ch; int phs; int s;} exp_t;
  exp_t q[$];
  int ma[4], mf[4], mo[4];
  int mslot = 0, exp_phs = 0;
  int checks = 0, errors = 0, pushed = 0, popped = 0;
  always #5 clk = ~clk;
  nco_tdm_sched dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data), .sine_phs(sine_phs),
    .sine_d(sine_d), .dout(dout), .dout_ch(dout_ch), .dout_vld(dout_vld), .frame(frame)
  );
  function automatic int sin_model(input int p);
    real r;
    r = $sin(2.0 * 3.14159265358979 * p / 4096.0) * 8191.0;
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction
  always @(posedge clk) begin
    p1 <= sine_phs;
    p2 <= p1;
    sine_d <= 14'(sin_model(int'(p2)));
  end
  always @(negedge clk) begin
    if (dout_vld === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: dout_vld=1 ch=%0d with nothing in flight", dout_ch);
      end else begin
        exp_t e;
        e = q.pop_front();
        popped++;
        if (int'(dout_ch) != e.ch || int'(dout) != e.s || frame !== (e.ch == 3)) begin
          errors++;
          $display("FAIL result: got ch=%0d dout=%0d frame=%b, want ch=%0d dout=%0d frame=%b (phase %0d)",
                   dout_ch, dout, frame, e.ch, e.s, e.ch == 3, e.phs);
        end
      end
    end else if (reset === 1'b0) begin
      checks++;
      if (frame !== 1'b0) begin
        errors++;
        $display("FAIL frame_idle: frame=%b while dout_vld=%b, want 0", frame, dout_vld);
      end
    end
  end
  task automatic chk_phs();
    checks++;
    if (int'(sine_phs) != exp_phs) begin
      errors++;
      $display("FAIL sine_phs: got %0d want %0d", sine_phs, exp_phs);
    end
  endtask
  task automatic step(input bit e, input bit c, input bit w, input bit s, input int ch, input int d);
    int ph;
    en = e; sync_clr = c; cfg_we = w; cfg_sel = s; cfg_ch = 2'(ch); cfg_data = 24'(d);
    if (c) begin
      for (int i = 0; i < 4; i++) ma[i] = 0;
      mslot = 0;
    end else if (e) begin
      ph = ((ma[mslot] / 4096) + mo[mslot]) % 4096;
      q.push_back('{mslot, ph, sin_model(ph)});
      pushed++;
      exp_phs = ph;
      ma[mslot] = (ma[mslot] + mf[mslot]) % (1 << 24);
      mslot = (mslot + 1) % 4;
    end
    if (w) begin
      if (s) mo[ch] = d % 4096;
      else mf[ch] = d % (1 << 24);
    end
    @(posedge clk); #1;
    chk_phs();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1; en = 1'b0; sync_clr = 1'b0; cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin ma[i] = 0; mf[i] = 0; mo[i] = 0; end
    mslot = 0; exp_phs = 0;
    pushed -= q.size();
    q.delete();
    reset = 1'b0;
  endtask
  initial begin
    do_reset();
    checks++;
    if (dout_vld !== 1'b0 || frame !== 1'b0 || dout !== 14'sd0 || dout_ch !== 2'd0 || sine_phs !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: vld=%b frame=%b dout=%0d ch=%0d phs=%0d, want all 0", dout_vld, frame, dout, dout_ch, sine_phs);
    end
    run(12);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 4096);
    run(16);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1, 1024);
    run(8);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2, 24'hFFFFFF);
    run(12);
    while (mslot != 3) run(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3, 8192);
    run(8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run(9);
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 77);
    run(8);
    for (int i = 0; i < 300; i++) begin
      bit w;
      w = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, w, 1'($urandom), int'($urandom_range(0, 3)),
           int'($urandom & 32'hFFFFFF));
    end
    run(3);
    do_reset();
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run(6);
    for (int i = 0; i < 12 && q.size() != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, popped %0d of %0d", q.size(), popped, pushed);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
